// File: rtl/trsq8_pkg.sv
// Shared constants for the TRSQ8 interrupt controller: register offsets,
// FSM state encodings and the VEC valid bit position.
package trsq8_pkg;

  localparam logic [7:0] OFS_PEND = 8'd0;
  localparam logic [7:0] OFS_MASK = 8'd1;
  localparam logic [7:0] OFS_EDGE = 8'd2;
  localparam logic [7:0] OFS_VEC  = 8'd3;
  localparam logic [7:0] OFS_CTRL = 8'd4;
  localparam logic [7:0] N_REGS   = 8'd5;

  localparam int VEC_VLD_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// 8-bit combinational priority encoder, lowest set index wins; zero latency,
// no flow control.
module intc_prio_enc (
  input  logic [7:0] i_req,
  output logic       o_vld,
  output logic [2:0] o_idx
);

  always_comb begin
    o_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_req[i]) o_idx = 3'(i);
    end
  end

  assign o_vld = |i_req;

endmodule

// File: rtl/trsq8_intc.sv
// Eight-source interrupt controller on the TRSQ8 peripheral bus; reads are
// combinational, irq_op is registered and follows pending state one cycle later.
module trsq8_intc
  import trsq8_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         N_SRC       = 8,
  parameter int         HOLDOFF_CYC = 2
) (
  input  logic       clk_ip,
  input  logic       reset_n_ip,
  input  logic [7:0] addr_ip,
  input  logic [7:0] data_ip,
  input  logic       wr_en_ip,
  input  logic       rd_en_ip,
  output logic [7:0] data_op,
  input  logic [7:0] src_ip,
  output logic       irq_op
);

  localparam logic [8:0] SRC_ONE = 9'd1 << N_SRC;
  localparam logic [7:0] SRC_MSK = SRC_ONE[7:0] - 8'd1;
  localparam logic [3:0] HOLD_LD = 4'(HOLDOFF_CYC - 1);

  logic [7:0] r_pend;
  logic [7:0] r_mask;
  logic [7:0] r_edge;
  logic       r_gie;
  logic [7:0] r_src_prev;
  state_e     r_state;
  logic [3:0] r_cnt;

  logic [7:0] w_ofs;
  logic       w_hit;
  logic       w_wr_pend;
  logic       w_wr_mask;
  logic       w_wr_edge;
  logic       w_wr_vec;
  logic       w_wr_ctrl;
  logic [7:0] w_pm;
  logic       w_vld;
  logic [2:0] w_idx;
  logic [7:0] w_w1c;
  logic [7:0] w_ack_clr;
  logic [7:0] w_rise;
  logic [7:0] w_edge_nxt;
  logic [7:0] w_pend_nxt;
  state_e     w_state_nxt;
  logic [3:0] w_cnt_nxt;

  assign w_ofs     = addr_ip - BASE_ADDR;
  assign w_hit     = (w_ofs < N_REGS);
  assign w_wr_pend = wr_en_ip && (w_ofs == OFS_PEND);
  assign w_wr_mask = wr_en_ip && (w_ofs == OFS_MASK);
  assign w_wr_edge = wr_en_ip && (w_ofs == OFS_EDGE);
  assign w_wr_vec  = wr_en_ip && (w_ofs == OFS_VEC);
  assign w_wr_ctrl = wr_en_ip && (w_ofs == OFS_CTRL);

  assign w_pm = r_pend & r_mask;

  intc_prio_enc u_prio_enc (
    .i_req (w_pm),
    .o_vld (w_vld),
    .o_idx (w_idx)
  );

  // Clears are applied before the new edge is ORed in, so a same-cycle set wins.
  assign w_w1c      = w_wr_pend ? data_ip : 8'd0;
  assign w_ack_clr  = (w_wr_vec && w_vld) ? (8'd1 << w_idx) : 8'd0;
  assign w_rise     = src_ip & ~r_src_prev;
  assign w_edge_nxt = (r_pend & ~(w_w1c | w_ack_clr)) | w_rise;
  assign w_pend_nxt = ((w_edge_nxt & r_edge) | (src_ip & ~r_edge)) & SRC_MSK;

  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      r_pend     <= 8'd0;
      r_mask     <= 8'd0;
      r_edge     <= SRC_MSK;
      r_gie      <= 1'b0;
      r_src_prev <= 8'd0;
    end else begin
      r_src_prev <= src_ip & SRC_MSK;
      r_pend     <= w_pend_nxt;
      if (w_wr_mask) r_mask <= data_ip & SRC_MSK;
      if (w_wr_edge) r_edge <= data_ip & SRC_MSK;
      if (w_wr_ctrl) r_gie  <= data_ip[0];
    end
  end

  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // HOLDOFF guarantees a low period so the CPU sees a fresh rising edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_gie && w_vld) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (w_wr_vec || !r_gie || !w_vld) begin
          w_state_nxt = ST_HOLDOFF;
          w_cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign irq_op = (r_state == ST_ASSERT);

  always_comb begin
    data_op = 8'd0;
    if (rd_en_ip && w_hit) begin
      case (w_ofs)
        OFS_PEND: data_op = r_pend;
        OFS_MASK: data_op = r_mask;
        OFS_EDGE: data_op = r_edge;
        OFS_VEC: begin
          data_op[VEC_VLD_BIT] = w_vld;
          data_op[2:0]         = w_idx;
        end
        OFS_CTRL: data_op = {7'd0, r_gie};
        default:  data_op = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_trsq8_intc.sv
// Scenario bench for trsq8_intc: expected values queued with the stimulus,
// observations queued as they are taken, then popped and compared per scenario.
module tb_trsq8_intc;

  localparam logic [7:0] A_PEND = 8'h10;
  localparam logic [7:0] A_MASK = 8'h11;
  localparam logic [7:0] A_EDGE = 8'h12;
  localparam logic [7:0] A_VEC  = 8'h13;
  localparam logic [7:0] A_CTRL = 8'h14;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] addr;
  logic [7:0] wdat;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rdat;
  logic [7:0] src;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  string      nm_q[$];

  always #5 clk = ~clk;

  trsq8_intc #(
    .BASE_ADDR   (8'h10),
    .N_SRC       (8),
    .HOLDOFF_CYC (2)
  ) dut (
    .clk_ip     (clk),
    .reset_n_ip (reset_n),
    .addr_ip    (addr),
    .data_ip    (wdat),
    .wr_en_ip   (wr_en),
    .rd_en_ip   (rd_en),
    .data_op    (rdat),
    .src_ip     (src),
    .irq_op     (irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdat  = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr  = a;
    rd_en = 1'b1;
    #1;
    d     = rdat;
    rd_en = 1'b0;
  endtask

  task automatic see(input string n, input logic [7:0] g);
    nm_q.push_back(n);
    got_q.push_back(g);
  endtask

  task automatic do_reset();
    src     = 8'd0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    wr(A_MASK, 8'h01);
    wr(A_CTRL, 8'h01);
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
    exp_q.push_back(8'h01); see("rst_pre_irq", {7'd0, irq});
    #2;
    reset_n = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    see("rst_async_irq", {7'd0, irq});
    exp_q.push_back(8'h00); rd(A_MASK, d); see("rst_mask", d);
    exp_q.push_back(8'hFF); rd(A_EDGE, d); see("rst_edge", d);
    exp_q.push_back(8'h00); rd(A_CTRL, d); see("rst_ctrl", d);
    exp_q.push_back(8'h00); rd(A_PEND, d); see("rst_pend", d);
    reset_n = 1'b1;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  task automatic test_single_edge();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    wr(A_MASK, 8'h01);
    wr(A_CTRL, 8'h01);
    src = 8'h01;
    tick();
    src = 8'h00;
    exp_q.push_back(8'h01); rd(A_PEND, d); see("se_pend", d);
    exp_q.push_back(8'h80); rd(A_VEC, d); see("se_vec", d);
    exp_q.push_back(8'h00); see("se_irq_k", {7'd0, irq});
    tick();
    exp_q.push_back(8'h01); see("se_irq_k1", {7'd0, irq});
    wr(A_VEC, 8'h5A);
    exp_q.push_back(8'h00); see("se_irq_ack", {7'd0, irq});
    exp_q.push_back(8'h00); rd(A_PEND, d); see("se_pend_ack", d);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(8'h00); see("se_irq_hold", {7'd0, irq});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  task automatic test_priority();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    wr(A_MASK, 8'hFF);
    wr(A_CTRL, 8'h01);
    src = 8'h24;
    tick();
    src = 8'h00;
    exp_q.push_back(8'h24); rd(A_PEND, d); see("pr_pend", d);
    exp_q.push_back(8'h82); rd(A_VEC, d); see("pr_vec2", d);
    tick();
    exp_q.push_back(8'h01); see("pr_irq", {7'd0, irq});
    wr(A_VEC, 8'h00);
    exp_q.push_back(8'h00); see("pr_irq_ack", {7'd0, irq});
    exp_q.push_back(8'h20); rd(A_PEND, d); see("pr_pend_ack", d);
    tick();
    exp_q.push_back(8'h00); see("pr_irq_m1", {7'd0, irq});
    tick();
    exp_q.push_back(8'h00); see("pr_irq_m2", {7'd0, irq});
    tick();
    exp_q.push_back(8'h01); see("pr_irq_m3", {7'd0, irq});
    exp_q.push_back(8'h85); rd(A_VEC, d); see("pr_vec5", d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  task automatic test_level();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    wr(A_MASK, 8'h08);
    wr(A_CTRL, 8'h01);
    wr(A_EDGE, 8'h00);
    src = 8'h08;
    tick();
    exp_q.push_back(8'h08); rd(A_PEND, d); see("lv_pend", d);
    tick();
    exp_q.push_back(8'h01); see("lv_irq", {7'd0, irq});
    wr(A_PEND, 8'h08);
    exp_q.push_back(8'h08); rd(A_PEND, d); see("lv_pend_w1c", d);
    exp_q.push_back(8'h01); see("lv_irq_w1c", {7'd0, irq});
    tick();
    exp_q.push_back(8'h01); see("lv_irq_hold", {7'd0, irq});
    src = 8'h00;
    tick();
    exp_q.push_back(8'h00); rd(A_PEND, d); see("lv_pend_low", d);
    exp_q.push_back(8'h01); see("lv_irq_a1", {7'd0, irq});
    src = 8'h08;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(8'h00); see("lv_irq_holdoff", {7'd0, irq});
    end
    tick();
    exp_q.push_back(8'h01); see("lv_irq_reassert", {7'd0, irq});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  task automatic test_set_clear();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    src = 8'h02;
    tick();
    src = 8'h00;
    tick();
    exp_q.push_back(8'h02); rd(A_PEND, d); see("sc_pend", d);
    src = 8'h02;
    wr(A_PEND, 8'h02);
    exp_q.push_back(8'h02); rd(A_PEND, d); see("sc_set_wins", d);
    src = 8'h00;
    wr(A_PEND, 8'h02);
    exp_q.push_back(8'h00); rd(A_PEND, d); see("sc_w1c", d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  task automatic test_mask_gie();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    wr(A_CTRL, 8'h01);
    src = 8'h10;
    tick();
    src = 8'h00;
    tick();
    exp_q.push_back(8'h10); rd(A_PEND, d); see("mg_pend", d);
    exp_q.push_back(8'h00); rd(A_VEC, d); see("mg_vec_masked", d);
    tick(3);
    exp_q.push_back(8'h00); see("mg_irq_masked", {7'd0, irq});
    wr(A_MASK, 8'h10);
    tick();
    exp_q.push_back(8'h01); see("mg_irq_on", {7'd0, irq});
    wr(A_CTRL, 8'h00);
    exp_q.push_back(8'h01); see("mg_irq_gie_edge", {7'd0, irq});
    tick();
    exp_q.push_back(8'h00); see("mg_irq_drop", {7'd0, irq});
    tick(4);
    exp_q.push_back(8'h00); see("mg_irq_gie_off", {7'd0, irq});
    exp_q.push_back(8'h84); rd(A_VEC, d); see("mg_vec_gie_off", d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  task automatic test_window();
    logic [7:0] d, e, g;
    string n;
    do_reset();
    wr(8'h15, 8'hFF);
    wr(8'h0F, 8'hFF);
    exp_q.push_back(8'h00); rd(A_MASK, d); see("win_mask", d);
    exp_q.push_back(8'h00); rd(8'h15, d); see("win_rd_out", d);
    exp_q.push_back(8'hFF); rd(A_EDGE, d); see("win_edge", d);
    addr = A_EDGE;
    exp_q.push_back(8'h00);
    #1;
    see("win_no_rden", rdat);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s got %02h required %02h", n, g, e); end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    addr    = 8'd0;
    wdat    = 8'd0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    src     = 8'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_edge();
    test_priority();
    test_level();
    test_set_clear();
    test_mask_gie();
    test_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
